// File: rtl/conv_main_controller.sv
// Convolution job sequencer: start handshake, row/filter counting, output-buffer stall handling.
// Strobes are combinational in the same cycle as their inputs; buf_full holds stores in STALL.
module conv_main_controller #(
  parameter int ROW_W  = 8,
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              av_data,
  input  logic              av_filter,
  input  logic              co_filter,
  input  logic              end_of_row,
  input  logic              end_of_filter,
  input  logic              buf_full,
  input  logic [ROW_W-1:0]  cfg_rows,
  output logic              ld_stride,
  output logic              ld_fileSize,
  output logic              put_data,
  output logic              put_filter,
  output logic              clear_sum,
  output logic              store_buffer,
  output logic              next_filter,
  output logic              next_row,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  row_idx,
  output logic [FILT_W-1:0] filter_idx
);

  typedef enum logic [2:0] {IDLE, ARMED, INIT, RUN, STALL, DONE} state_t;

  state_t           state;
  logic [ROW_W-1:0] limit;
  logic [ROW_W-1:0] last_idx;
  logic             pend_eor;
  logic             pend_eof;
  logic             stall_hit;

  // cfg_rows = 0 wraps to all-ones here, giving 2^ROW_W rows.
  assign last_idx = limit - ROW_W'(1);

  always_comb begin
    ld_stride    = 1'b0;
    ld_fileSize  = 1'b0;
    put_data     = 1'b0;
    put_filter   = 1'b0;
    clear_sum    = 1'b0;
    store_buffer = 1'b0;
    next_filter  = 1'b0;
    next_row     = 1'b0;
    stall_hit    = 1'b0;
    case (state)
      INIT: begin
        ld_stride   = 1'b1;
        ld_fileSize = 1'b1;
      end
      RUN: begin
        stall_hit    = co_filter & buf_full;
        put_data     = av_data & av_filter & ~buf_full;
        put_filter   = av_data & av_filter & ~buf_full;
        clear_sum    = co_filter & ~buf_full;
        store_buffer = co_filter & ~buf_full;
        next_filter  = end_of_row & ~stall_hit;
        next_row     = end_of_row & end_of_filter & ~stall_hit;
      end
      STALL: begin
        // Exit cycle completes the held store and replays the deferred row events.
        clear_sum    = ~buf_full;
        store_buffer = ~buf_full;
        next_filter  = ~buf_full & pend_eor;
        next_row     = ~buf_full & pend_eor & pend_eof;
      end
      default: ;
    endcase
  end

  assign busy = (state == INIT) || (state == RUN) || (state == STALL);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row_idx    <= '0;
      filter_idx <= '0;
      limit      <= '0;
      pend_eor   <= 1'b0;
      pend_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (start) state <= ARMED;
        ARMED: if (!start) state <= INIT;
        INIT: begin
          row_idx    <= '0;
          filter_idx <= '0;
          limit      <= cfg_rows;
          pend_eor   <= 1'b0;
          pend_eof   <= 1'b0;
          state      <= RUN;
        end
        RUN, STALL: begin
          if (stall_hit) begin
            pend_eor <= end_of_row;
            pend_eof <= end_of_filter;
            state    <= STALL;
          end else if (state == RUN || !buf_full) begin
            state <= RUN;
            if (next_row) begin
              filter_idx <= '0;
              if (row_idx == last_idx) state <= DONE;
              else row_idx <= row_idx + ROW_W'(1);
            end else if (next_filter) begin
              filter_idx <= filter_idx + FILT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_main_controller.sv
// Directed plus random bench for conv_main_controller against a job-level reference model.
module tb_conv_main_controller;

  localparam int ROW_W  = 3;
  localparam int FILT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, av_data = 1'b0, av_filter = 1'b0, co_filter = 1'b0;
  logic end_of_row = 1'b0, end_of_filter = 1'b0, buf_full = 1'b0;
  logic [ROW_W-1:0]  cfg_rows = '0;
  logic ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer;
  logic next_filter, next_row, busy, done;
  logic [ROW_W-1:0]  row_idx;
  logic [FILT_W-1:0] filter_idx;

  conv_main_controller #(.ROW_W(ROW_W), .FILT_W(FILT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .av_data(av_data), .av_filter(av_filter),
    .co_filter(co_filter), .end_of_row(end_of_row), .end_of_filter(end_of_filter),
    .buf_full(buf_full), .cfg_rows(cfg_rows), .ld_stride(ld_stride), .ld_fileSize(ld_fileSize),
    .put_data(put_data), .put_filter(put_filter), .clear_sum(clear_sum),
    .store_buffer(store_buffer), .next_filter(next_filter), .next_row(next_row),
    .busy(busy), .done(done), .row_idx(row_idx), .filter_idx(filter_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase plus plain counts of completed rows and filters.
  typedef enum int {P_IDLE, P_ARMED, P_INIT, P_RUN, P_STALL, P_DONE} phase_t;
  phase_t phase;
  int rows_done, rows_total, filt_cnt;
  bit p_eor, p_eof;
  int nr_seen, done_seen, ld_seen;

  function automatic void model_reset();
    phase = P_IDLE;
    rows_done = 0;
    rows_total = 1;
    filt_cnt = 0;
    p_eor = 0;
    p_eof = 0;
  endfunction

  // Order: ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer, next_filter, next_row, busy, done
  function automatic logic [9:0] exp_strobes();
    bit put, st, nf, nr, stall_now;
    if (!rst) return 10'b0;
    case (phase)
      P_INIT: return 10'b1100000010;
      P_RUN: begin
        stall_now = co_filter && buf_full;
        put = av_data && av_filter && !buf_full;
        st  = co_filter && !buf_full;
        nf  = end_of_row && !stall_now;
        nr  = nf && end_of_filter;
        return {2'b00, put, put, st, st, nf, nr, 2'b10};
      end
      P_STALL: begin
        st = !buf_full;
        nf = st && p_eor;
        nr = nf && p_eof;
        return {4'b0000, st, st, nf, nr, 2'b10};
      end
      P_DONE: return 10'b0000000001;
      default: return 10'b0;
    endcase
  endfunction

  function automatic void finish_row_events(bit e, bit f);
    if (e && f) begin
      rows_done++;
      filt_cnt = 0;
      if (rows_done == rows_total) phase = P_DONE;
    end else if (e) begin
      filt_cnt++;
    end
  endfunction

  function automatic void model_advance();
    if (!rst) begin
      model_reset();
      return;
    end
    case (phase)
      P_IDLE:  if (start) phase = P_ARMED;
      P_ARMED: if (!start) phase = P_INIT;
      P_INIT: begin
        rows_done = 0;
        filt_cnt = 0;
        rows_total = (cfg_rows == 0) ? (1 << ROW_W) : int'(cfg_rows);
        phase = P_RUN;
      end
      P_RUN: begin
        if (co_filter && buf_full) begin
          p_eor = end_of_row;
          p_eof = end_of_filter;
          phase = P_STALL;
        end else begin
          finish_row_events(end_of_row, end_of_filter);
        end
      end
      P_STALL: begin
        if (!buf_full) begin
          phase = P_RUN;
          finish_row_events(p_eor, p_eof);
        end
      end
      P_DONE: phase = P_IDLE;
      default: phase = P_IDLE;
    endcase
  endfunction

  // Called just after a falling edge with inputs already set; checks, then crosses one rising edge.
  task automatic tick();
    logic [9:0] obs, exp_s;
    logic [ROW_W-1:0] exp_row;
    logic [FILT_W-1:0] exp_filt;
    #1;
    if (!rst) model_reset();
    exp_s = exp_strobes();
    exp_row = (rows_done >= rows_total) ? ROW_W'(rows_total - 1) : ROW_W'(rows_done);
    exp_filt = FILT_W'(filt_cnt % (1 << FILT_W));
    obs = {ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer,
           next_filter, next_row, busy, done};
    checks++;
    assert (obs === exp_s) else begin
      errors++;
      $error("FAIL strobes t=%0t observed=%b expected=%b", $time, obs, exp_s);
    end
    checks++;
    assert (row_idx === exp_row) else begin
      errors++;
      $error("FAIL row_idx t=%0t observed=%0d expected=%0d", $time, row_idx, exp_row);
    end
    checks++;
    assert (filter_idx === exp_filt) else begin
      errors++;
      $error("FAIL filter_idx t=%0t observed=%0d expected=%0d", $time, filter_idx, exp_filt);
    end
    nr_seen += int'(next_row);
    done_seen += int'(done);
    ld_seen += int'(ld_stride && ld_fileSize);
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; av_data = 0; av_filter = 0; co_filter = 0;
    end_of_row = 0; end_of_filter = 0; buf_full = 0;
  endtask

  task automatic launch_job(input logic [ROW_W-1:0] rows, input int hold);
    cfg_rows = rows;
    start = 1;
    repeat (hold) tick();
    start = 0;
    tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset state.
    repeat (2) tick();
    rst = 1;
    repeat (2) tick();

    // Start held 3 cycles then released: exactly one INIT cycle.
    ld_seen = 0;
    launch_job(3'd2, 3);
    repeat (2) tick();
    checks++;
    assert (ld_seen === 1) else begin
      errors++;
      $error("FAIL init_count observed=%0d expected=1", ld_seen);
    end

    // Two rows, three end_of_row pulses each with end_of_filter on the third.
    nr_seen = 0; done_seen = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        end_of_row = 1; end_of_filter = (p == 2); tick();
        end_of_row = 0; end_of_filter = 0; tick();
      end
    end
    tick();
    checks++;
    assert (nr_seen === 2 && done_seen === 1) else begin
      errors++;
      $error("FAIL two_row_job next_row=%0d done=%0d expected 2 and 1", nr_seen, done_seen);
    end

    // Stall: co_filter under buf_full for 4 cycles, with a deferred end_of_row.
    launch_job(3'd1, 1);
    tick();
    co_filter = 1; buf_full = 1; end_of_row = 1; tick();
    co_filter = 0; end_of_row = 0; av_data = 1; av_filter = 1; end_of_filter = 1;
    repeat (3) tick();
    av_data = 0; av_filter = 0; end_of_filter = 0; buf_full = 0; tick();
    tick();

    // Put strobes against availability and buf_full.
    av_data = 1; av_filter = 0; tick();
    av_filter = 1; tick();
    buf_full = 1; tick();
    buf_full = 0;
    // Start during RUN is ignored.
    start = 1; tick();
    start = 0; tick();
    end_of_row = 1; tick();
    end_of_row = 0; tick();

    // Asynchronous reset between edges mid-RUN.
    #2 rst = 0;
    #1;
    checks++;
    assert ({ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer,
             next_filter, next_row, busy, done, row_idx, filter_idx} === '0) else begin
      errors++;
      $error("FAIL async_reset outputs not cleared before clock edge, filter_idx=%0d busy=%b",
             filter_idx, busy);
    end
    model_reset();
    idle_inputs();
    tick();
    rst = 1;
    tick();

    // cfg_rows=0 means 8 rows with ROW_W=3.
    launch_job(3'd0, 2);
    nr_seen = 0; done_seen = 0;
    end_of_row = 1; end_of_filter = 1;
    for (int i = 0; i < 20 && done_seen == 0; i++) tick();
    idle_inputs();
    tick();
    checks++;
    assert (nr_seen === 8 && done_seen === 1) else begin
      errors++;
      $error("FAIL zero_rows_job next_row=%0d done=%0d expected 8 and 1", nr_seen, done_seen);
    end

    // Random traffic against the model.
    done_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 7) == 0);
      av_data       = $urandom_range(0, 1) == 1;
      av_filter     = $urandom_range(0, 1) == 1;
      co_filter     = ($urandom_range(0, 3) == 0);
      end_of_row    = ($urandom_range(0, 4) < 2);
      end_of_filter = $urandom_range(0, 1) == 1;
      buf_full      = ($urandom_range(0, 3) == 0);
      cfg_rows      = ROW_W'($urandom_range(0, 7));
      rst           = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1;
    idle_inputs();
    tick();
    checks++;
    assert (done_seen > 0) else begin
      errors++;
      $error("FAIL random_jobs completed=%0d expected>0", done_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_main_controller.md
CONV_MAIN_CONTROLLER -- requirements
Module: conv_main_controller

Interface
REQ-001 SHALL have parameter ROW_W, default 8, width of the row counter, cfg_rows and row_idx.
REQ-002 SHALL have parameter FILT_W, default 4, width of the filter counter and filter_idx.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, start request; acted on only after its release.
REQ-006 SHALL have ports av_data and av_filter, input, 1 each, data/filter word available.
REQ-007 SHALL have port co_filter, input, 1, current filter window accumulation complete.
REQ-008 SHALL have ports end_of_row and end_of_filter, input, 1 each, end of row and end of last filter.
REQ-009 SHALL have port buf_full, input, 1, output buffer cannot accept a store.
REQ-010 SHALL have port cfg_rows, input, ROW_W, number of rows per job; sampled in INIT.
REQ-011 SHALL have ports ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer, next_filter and next_row, output, 1 each, datapath strobes.
REQ-012 SHALL have ports busy and done, output, 1 each; row_idx output, ROW_W; filter_idx output, FILT_W.

Function
REQ-013 SHALL implement states IDLE, ARMED, INIT, RUN, STALL and DONE.
REQ-014 SHALL make all strobe outputs combinational from state and inputs, and row_idx, filter_idx and the stored row limit registered.
REQ-015 SHALL move IDLE->ARMED when start=1; ARMED holds while start=1 and moves to INIT when start=0.
REQ-016 SHALL spend exactly one cycle in INIT: ld_stride=ld_fileSize=1, row_idx<=0, filter_idx<=0, limit<=cfg_rows, then move to RUN.
REQ-017 SHALL treat cfg_rows=0 as 2^ROW_W rows.
REQ-018 SHALL drive put_data=put_filter=av_data&av_filter&~buf_full in RUN.
REQ-019 SHALL drive clear_sum=store_buffer=1 in RUN when co_filter=1 and buf_full=0.
REQ-020 SHALL move RUN->STALL when co_filter=1 and buf_full=1, with no store, clear or put that cycle.
REQ-021 SHALL drive only busy in STALL and ignore all inputs there except buf_full.
REQ-022 SHALL, on the cycle buf_full=0 is seen in STALL, drive store_buffer=clear_sum=1 and move to RUN.
REQ-023 SHALL drive next_filter=end_of_row in RUN and increment filter_idx modulo 2^FILT_W.
REQ-024 SHALL drive next_row=end_of_row&end_of_filter in RUN, set filter_idx<=0 (overriding the increment) and increment row_idx.
REQ-025 SHALL move RUN->DONE when next_row=1 and row_idx=limit-1 (modulo 2^ROW_W); row_idx then holds that final value.
REQ-026 SHALL process co_filter and end_of_row in the same RUN cycle together; if that co_filter stalls, the end_of_row events are deferred and replayed on the STALL exit cycle.
REQ-027 SHALL stay in DONE one cycle with done=1, then move to IDLE; row_idx and filter_idx hold until the next INIT.
REQ-028 SHALL drive busy=1 in INIT, RUN and STALL, and 0 otherwise.
REQ-029 SHALL ignore start outside IDLE and ARMED.
REQ-030 SHALL drive every strobe to 0 in IDLE, ARMED and DONE.

Reset
REQ-031 SHALL, while rst=0, force state IDLE, row_idx=0, filter_idx=0, limit=0 and all outputs 0, independent of clk.
REQ-032 SHALL abort an active job on reset assertion in any state with no further strobes; after release it requires a fresh start press and release.

Verification
REQ-033 SHALL pass start held 3 cycles then released -> exactly one INIT cycle with ld_stride=ld_fileSize=1, then busy=1.
REQ-034 SHALL pass cfg_rows=2, FILT_W=4, three end_of_row pulses per row with end_of_filter on the third -> filter_idx 0,1,2,0; next_row twice; done=1 one cycle after the second next_row.
REQ-035 SHALL pass co_filter with buf_full=1 held 4 cycles -> no store_buffer for 4 cycles, then one store_buffer+clear_sum cycle, back in RUN.
REQ-036 SHALL pass av_data=1, av_filter=0 -> put_data=put_filter=0; both 1 -> put strobes 1; buf_full=1 -> put strobes 0.
REQ-037 SHALL pass rst=0 asserted mid-RUN between clock edges -> outputs 0 immediately; start during RUN -> ignored.
REQ-038 SHALL pass cfg_rows=0 with ROW_W=3 -> DONE after 8 next_row pulses.
